// File: rtl/mem_align_unit_pkg.sv
// Shared load/store codes and FSM encodings for the memory alignment unit.
// Imported by the top and the load-merge sub-module.
package mem_align_unit_pkg;

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LB      = 3'd1;
   localparam logic [2:0] LH      = 3'd2;
   localparam logic [2:0] LW      = 3'd3;
   localparam logic [2:0] LBU     = 3'd4;
   localparam logic [2:0] LHU     = 3'd5;

   localparam logic [1:0] ST_NONE = 2'd0;
   localparam logic [1:0] SB      = 2'd1;
   localparam logic [1:0] SH      = 2'd2;
   localparam logic [1:0] SW      = 2'd3;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LD_HI   = 2'd1;
   localparam logic [1:0] S_ST_BYTE = 2'd2;

   function automatic logic is_load(input logic [2:0] c);
      return (c == LB) || (c == LH) || (c == LW) || (c == LBU) || (c == LHU);
   endfunction

   function automatic logic is_store(input logic [1:0] c);
      return (c == SB) || (c == SH) || (c == SW);
   endfunction

endpackage

// File: rtl/misalign_load_merge.sv
// Assembles a split load from two aligned words and applies the
// sign/zero extension of the original load code.
module misalign_load_merge
   import mem_align_unit_pkg::*;
(
   input  logic [31:0] lo,
   input  logic [31:0] hi,
   input  logic [1:0]  rem,
   input  logic [2:0]  info_load,
   output logic [31:0] result
);

   logic [63:0] cat;
   logic [31:0] sh;

   assign cat = {hi, lo};
   assign sh  = cat[{rem, 3'b000} +: 32];

   always_comb begin
      result = sh;
      unique case (1'b1)
         (info_load == LH):  result = {{16{sh[15]}}, sh[15:0]};
         (info_load == LHU): result = {16'd0, sh[15:0]};
         default:            result = sh;
      endcase
   end

endmodule

// File: rtl/mem_align_unit.sv
// Splits misaligned EX memory requests into aligned datamem accesses;
// aligned traffic passes straight through with no added latency.
module mem_align_unit
   import mem_align_unit_pkg::*;
#(
   parameter int ENABLE_SPLIT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  info_load,
   input  logic [1:0]  info_store,
   input  logic [31:0] alu_result,
   input  logic [31:0] rs2,
   input  logic        write_reg,
   input  logic [4:0]  dst_addr,
   input  logic [31:0] m_load_data,
   output logic [2:0]  m_info_load,
   output logic [1:0]  m_info_store,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_write_reg,
   output logic [4:0]  m_dst_addr,
   output logic        stall,
   output logic        wb_override,
   output logic [31:0] split_data
);

   logic [1:0]  state;
   logic [2:0]  l_load;
   logic [1:0]  l_store;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic        l_wreg;
   logic [4:0]  l_dst;
   logic [31:0] lo;
   logic [1:0]  k;

   logic        ld_v, ld_mis, st_mis, go_ld, go_st;
   logic [1:0]  rem, last_k;
   logic [31:0] hi_addr, merged;
   logic [7:0]  wbyte;

   assign rem    = alu_result[1:0];
   assign ld_v   = is_load(info_load);
   // Load wins when both codes are valid.
   assign ld_mis = ld_v &&
                   ((info_load == LW && rem != 2'd0) ||
                    ((info_load == LH || info_load == LHU) && rem == 2'd3));
   assign st_mis = !ld_v && is_store(info_store) &&
                   ((info_store == SW && rem != 2'd0) ||
                    (info_store == SH && rem == 2'd3));
   assign go_ld  = (ENABLE_SPLIT != 0) && ld_mis;
   assign go_st  = (ENABLE_SPLIT != 0) && st_mis;

   assign hi_addr = {l_addr[31:2], 2'b00} + 32'd4;
   assign last_k  = (l_store == SW) ? 2'd3 : 2'd1;
   assign wbyte   = l_wdata[{k, 3'b000} +: 8];

   misalign_load_merge u_merge (
      .lo        (lo),
      .hi        (m_load_data),
      .rem       (l_addr[1:0]),
      .info_load (l_load),
      .result    (merged)
   );

   always_comb begin
      m_info_load  = info_load;
      m_info_store = info_store;
      m_addr       = alu_result;
      m_wdata      = rs2;
      m_write_reg  = write_reg;
      m_dst_addr   = dst_addr;
      stall        = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (go_ld) begin
               m_info_load  = LW;
               m_info_store = ST_NONE;
               m_addr       = {alu_result[31:2], 2'b00};
               m_write_reg  = 1'b0;
               stall        = 1'b1;
            end else if (go_st) begin
               m_info_load  = LD_NONE;
               m_info_store = SB;
               m_wdata      = {24'd0, rs2[7:0]};
               m_write_reg  = 1'b0;
               stall        = 1'b1;
            end
         end
         S_LD_HI: begin
            m_info_load  = LW;
            m_info_store = ST_NONE;
            m_addr       = hi_addr;
            m_wdata      = l_wdata;
            m_write_reg  = l_wreg;
            m_dst_addr   = l_dst;
         end
         S_ST_BYTE: begin
            m_info_load  = LD_NONE;
            m_info_store = SB;
            m_addr       = l_addr + {30'd0, k};
            m_wdata      = {24'd0, wbyte};
            m_write_reg  = 1'b0;
            m_dst_addr   = l_dst;
            stall        = (k != last_k);
         end
         default: ;
      endcase
      if (rst) begin
         stall        = 1'b0;
         m_write_reg  = 1'b0;
         m_info_store = ST_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wb_override <= 1'b0;
         split_data  <= 32'd0;
         l_load      <= LD_NONE;
         l_store     <= ST_NONE;
         l_addr      <= 32'd0;
         l_wdata     <= 32'd0;
         l_wreg      <= 1'b0;
         l_dst       <= 5'd0;
         lo          <= 32'd0;
         k           <= 2'd0;
      end else begin
         wb_override <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (go_ld || go_st) begin
                  l_load  <= info_load;
                  l_store <= info_store;
                  l_addr  <= alu_result;
                  l_wdata <= rs2;
                  l_wreg  <= write_reg;
                  l_dst   <= dst_addr;
               end
               if (go_ld) begin
                  lo    <= m_load_data;
                  state <= S_LD_HI;
               end else if (go_st) begin
                  k     <= 2'd1;
                  state <= S_ST_BYTE;
               end
            end
            S_LD_HI: begin
               split_data  <= merged;
               wb_override <= 1'b1;
               state       <= S_IDLE;
            end
            S_ST_BYTE: begin
               k <= k + 2'd1;
               if (k == last_k) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_align_unit.sv
// Bench for mem_align_unit: pass-through vector table plus split load/store
// sequences against a small byte-writable datamem model.
module tb_mem_align_unit;
   import mem_align_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  info_load;
   logic [1:0]  info_store;
   logic [31:0] alu_result, rs2;
   logic        write_reg;
   logic [4:0]  dst_addr;
   logic [31:0] m_load_data;
   logic [2:0]  m_info_load;
   logic [1:0]  m_info_store;
   logic [31:0] m_addr, m_wdata;
   logic        m_write_reg;
   logic [4:0]  m_dst_addr;
   logic        stall, wb_override;
   logic [31:0] split_data;

   logic [31:0] m_load_data_p;
   logic [2:0]  m_info_load_p;
   logic [1:0]  m_info_store_p;
   logic [31:0] m_addr_p, m_wdata_p;
   logic        m_write_reg_p;
   logic [4:0]  m_dst_addr_p;
   logic        stall_p, wb_override_p;
   logic [31:0] split_data_p;

   // 16-word memory aliased on addr[5:2]; tests reload it before use
   logic [31:0] mem [0:15];
   logic        pl_en = 1'b0;
   logic [3:0]  pl_idx;
   logic [31:0] pl_val;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   mem_align_unit #(.ENABLE_SPLIT(1)) dut (
      .clk(clk), .rst(rst),
      .info_load(info_load), .info_store(info_store),
      .alu_result(alu_result), .rs2(rs2),
      .write_reg(write_reg), .dst_addr(dst_addr),
      .m_load_data(m_load_data),
      .m_info_load(m_info_load), .m_info_store(m_info_store),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .m_write_reg(m_write_reg), .m_dst_addr(m_dst_addr),
      .stall(stall), .wb_override(wb_override), .split_data(split_data)
   );

   mem_align_unit #(.ENABLE_SPLIT(0)) dut_p (
      .clk(clk), .rst(rst),
      .info_load(info_load), .info_store(info_store),
      .alu_result(alu_result), .rs2(rs2),
      .write_reg(write_reg), .dst_addr(dst_addr),
      .m_load_data(m_load_data_p),
      .m_info_load(m_info_load_p), .m_info_store(m_info_store_p),
      .m_addr(m_addr_p), .m_wdata(m_wdata_p),
      .m_write_reg(m_write_reg_p), .m_dst_addr(m_dst_addr_p),
      .stall(stall_p), .wb_override(wb_override_p),
      .split_data(split_data_p)
   );

   assign m_load_data   = mem[m_addr[5:2]];
   assign m_load_data_p = mem[m_addr_p[5:2]];

   function automatic logic [31:0] wr_merge(input logic [31:0] old,
      input logic [1:0] st, input logic [1:0] a, input logic [31:0] d);
      logic [31:0] r;
      r = old;
      case (st)
         SB: r[{a, 3'b000} +: 8] = d[7:0];
         SH: r[{a[1], 4'b0000} +: 16] = d[15:0];
         SW: r = d;
         default: ;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (pl_en)
         mem[pl_idx] <= pl_val;
      else if (m_info_store != ST_NONE)
         mem[m_addr[5:2]] <= wr_merge(mem[m_addr[5:2]], m_info_store,
                                      m_addr[1:0], m_wdata);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in;
      info_load  = LD_NONE;
      info_store = ST_NONE;
      alu_result = 32'd0;
      rs2        = 32'd0;
      write_reg  = 1'b0;
      dst_addr   = 5'd0;
   endtask

   task automatic preload(input logic [3:0] idx, input logic [31:0] v);
      pl_en  = 1'b1;
      pl_idx = idx;
      pl_val = v;
      step;
      pl_en  = 1'b0;
   endtask

   task automatic do_load(input logic [2:0] code, input logic [31:0] a,
                          input logic [31:0] exp);
      logic [31:0] w;
      int          cyc;
      w = {a[31:2], 2'b00};
      info_load  = code;
      info_store = ST_NONE;
      alu_result = a;
      write_reg  = 1'b1;
      dst_addr   = 5'd7;
      #1;
      chk("ld_stall_lo", {31'd0, stall}, 32'd1);
      chk("ld_addr_lo", m_addr, w);
      chk("ld_wreg_lo", {31'd0, m_write_reg}, 32'd0);
      exp_q.push_back(exp);
      step;
      idle_in;
      #1;
      chk("ld_stall_hi", {31'd0, stall}, 32'd0);
      chk("ld_code_hi", {29'd0, m_info_load}, {29'd0, LW});
      chk("ld_addr_hi", m_addr, w + 32'd4);
      chk("ld_wreg_hi", {31'd0, m_write_reg}, 32'd1);
      chk("ld_dst_hi", {27'd0, m_dst_addr}, 32'd7);
      step;
      cyc = 0;
      while (!wb_override && cyc < 4) begin
         step;
         cyc++;
      end
      chk("ld_latency", cyc, 32'd0);
      if (wb_override) chk("split_data", split_data, exp_q.pop_front());
      step;
      chk("wb_pulse", {31'd0, wb_override}, 32'd0);
   endtask

   task automatic do_store(input logic [1:0] code, input logic [31:0] a,
                           input logic [31:0] d, input int n);
      info_load  = LD_NONE;
      info_store = code;
      alu_result = a;
      rs2        = d;
      #1;
      for (int j = 0; j < n; j++) begin
         chk("st_code", {30'd0, m_info_store}, {30'd0, SB});
         chk("st_addr", m_addr, a + j);
         chk("st_byte", {24'd0, m_wdata[7:0]}, {24'd0, d[8*j +: 8]});
         chk("st_stall", {31'd0, stall}, (j < n - 1) ? 32'd1 : 32'd0);
         step;
         if (j == 0) idle_in;
         #1;
      end
      chk("st_done", {30'd0, m_info_store}, {30'd0, ST_NONE});
   endtask

   typedef struct {
      logic [2:0]  ld;
      logic [1:0]  st;
      logic [31:0] a;
      logic        wr;
      logic [2:0]  eld;
      logic [1:0]  est;
      logic [31:0] ea;
      logic        ewr;
   } vec_t;

   vec_t vt [12];

   initial begin
      vt[0]  = '{LW,      ST_NONE, 32'h100, 1'b1, LW,      ST_NONE, 32'h100, 1'b1};
      vt[1]  = '{LH,      ST_NONE, 32'h102, 1'b1, LH,      ST_NONE, 32'h102, 1'b1};
      vt[2]  = '{LHU,     ST_NONE, 32'h101, 1'b1, LHU,     ST_NONE, 32'h101, 1'b1};
      vt[3]  = '{LB,      ST_NONE, 32'h103, 1'b1, LB,      ST_NONE, 32'h103, 1'b1};
      vt[4]  = '{LBU,     ST_NONE, 32'h107, 1'b1, LBU,     ST_NONE, 32'h107, 1'b1};
      vt[5]  = '{LD_NONE, SW,      32'h104, 1'b0, LD_NONE, SW,      32'h104, 1'b0};
      vt[6]  = '{LD_NONE, SH,      32'h102, 1'b0, LD_NONE, SH,      32'h102, 1'b0};
      vt[7]  = '{LD_NONE, SB,      32'h103, 1'b0, LD_NONE, SB,      32'h103, 1'b0};
      vt[8]  = '{LW,      SW,      32'h108, 1'b1, LW,      SW,      32'h108, 1'b1};
      vt[9]  = '{LD_NONE, ST_NONE, 32'h101, 1'b0, LD_NONE, ST_NONE, 32'h101, 1'b0};
      vt[10] = '{LD_NONE, SH,      32'h101, 1'b0, LD_NONE, SH,      32'h101, 1'b0};
      vt[11] = '{LW,      ST_NONE, 32'hC000_0000, 1'b1, LW, ST_NONE, 32'hC000_0000, 1'b1};

      idle_in;
      rst = 1'b1;
      step;
      step;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_wb", {31'd0, wb_override}, 32'd0);
      chk("rst_split", split_data, 32'd0);
      chk("rst_store", {30'd0, m_info_store}, {30'd0, ST_NONE});
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         info_load  = vt[i].ld;
         info_store = vt[i].st;
         alu_result = vt[i].a;
         rs2        = 32'hCAFE_0000 + i;
         write_reg  = vt[i].wr;
         dst_addr   = 5'(i + 1);
         #1;
         chk("pt_load", {29'd0, m_info_load}, {29'd0, vt[i].eld});
         chk("pt_store", {30'd0, m_info_store}, {30'd0, vt[i].est});
         chk("pt_addr", m_addr, vt[i].ea);
         chk("pt_wdata", m_wdata, 32'hCAFE_0000 + i);
         chk("pt_wreg", {31'd0, m_write_reg}, {31'd0, vt[i].ewr});
         chk("pt_stall", {31'd0, stall}, 32'd0);
         step;
         chk("pt_wb", {31'd0, wb_override}, 32'd0);
      end
      idle_in;

      info_load  = LW;
      alu_result = 32'h101;
      #1;
      chk("nosplit_addr", m_addr_p, 32'h101);
      chk("nosplit_code", {29'd0, m_info_load_p}, {29'd0, LW});
      chk("nosplit_stall", {31'd0, stall_p}, 32'd0);
      idle_in;
      info_store = SW;
      alu_result = 32'h102;
      #1;
      chk("nosplit_st", {30'd0, m_info_store_p}, {30'd0, SW});
      chk("nosplit_st_stall", {31'd0, stall_p}, 32'd0);
      idle_in;

      preload(4'd0, 32'h4433_2211);
      preload(4'd1, 32'h8877_6655);
      do_load(LW, 32'h101, 32'h5544_3322);
      do_load(LH, 32'h103, 32'h0000_5544);
      preload(4'd1, 32'h8877_66F5);
      do_load(LH, 32'h103, 32'hFFFF_F544);
      do_load(LHU, 32'h103, 32'h0000_F544);
      preload(4'd15, 32'hAABB_CCDD);
      preload(4'd0, 32'h1234_5678);
      do_load(LW, 32'hFFFF_FFFE, 32'h5678_AABB);

      preload(4'd0, 32'h4433_2211);
      preload(4'd1, 32'h8877_6655);
      do_store(SW, 32'h102, 32'hDDCC_BBAA, 4);
      chk("sw_mem0", mem[0], 32'hBBAA_2211);
      chk("sw_mem1", mem[1], 32'h8877_DDCC);

      preload(4'd2, 32'h0000_0000);
      do_store(SH, 32'h107, 32'h0000_BEEF, 2);
      chk("sh_mem1", mem[1], 32'hEF77_DDCC);
      chk("sh_mem2", mem[2], 32'h0000_00BE);

      preload(4'd0, 32'h0000_0000);
      preload(4'd1, 32'h8877_6655);
      info_store = SW;
      alu_result = 32'h101;
      rs2        = 32'h1122_3344;
      #1;
      chk("rst_sw_stall0", {31'd0, stall}, 32'd1);
      step;
      idle_in;
      rst = 1'b1;
      #1;
      chk("rst_mid_stall", {31'd0, stall}, 32'd0);
      chk("rst_mid_store", {30'd0, m_info_store}, {30'd0, ST_NONE});
      chk("rst_mid_wreg", {31'd0, m_write_reg}, 32'd0);
      step;
      rst = 1'b0;
      #1;
      chk("rst_after_stall", {31'd0, stall}, 32'd0);
      chk("rst_after_store", {30'd0, m_info_store}, {30'd0, ST_NONE});
      step;
      chk("rst_mem0", mem[0], 32'h0000_4400);
      chk("rst_mem1", mem[1], 32'h8877_6655);
      chk("rst_wb", {31'd0, wb_override}, 32'd0);

      chk("nosplit_wb", {31'd0, wb_override_p}, 32'd0);
      chk("q_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
